alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
Parametrised, registered successor to the CPU's single-cycle 8-bit ALU.
- Generalised to WIDTH bits.
- Adds arithmetic shift right (ASR), unsigned DIV and MOD, and a flags output.
- Uses a start/busy/result_valid handshake, so long operations (iterative MUL, DIV, MOD) run over multiple cycles while the control unit stalls.
- Sits between the register file and the writeback mux. Operand A is r0; operand B is selected between rX and the immediate.

Parameters:
WIDTH, 8, datapath width in bits; must be >= 2.
MUL_ITERATIVE, 1, 1 = shift-add multiply over WIDTH cycles; 0 = single-cycle combinational multiply.

Ports:
clk  in  1  system clock, rising edge.
rst_async  in  1  asynchronous, active-low reset.
start  in  1  request; accepted only when the block is not busy.
alu_operation  in  alu_operation_t  operation select, sampled on accept.
alu_operand  in  alu_operand_t  operand B select (ALU_RX / ALU_IMMEDIATE), sampled on accept.
r0  in  WIDTH  operand A.
rX  in  WIDTH  operand B candidate.
immediate  in  WIDTH  operand B candidate.
busy  out  1  iterative operation in progress.
result_valid  out  1  one-cycle pulse: result/flags updated this cycle.
alu_result  out  WIDTH  registered result; holds until the next completion.
alu_flags  out  alu_flags_t  registered {z, n, c, v, dz}; holds with alu_result.

Behaviour:
- Reset (rst_async low, asynchronous): state IDLE, busy 0, result_valid 0, alu_result 0, alu_flags all 0, iteration counter 0.
- FSM states:
  - IDLE: waiting for a request.
  - RUN: iterating; busy = 1.
  - DONE: result_valid = 1, busy = 0.
- Accept condition: start = 1 and state is IDLE or DONE. Start during RUN is ignored (not queued). On accept, operands and operation are latched; later input changes have no effect.
- Single-cycle ops (ADD SUB AND OR XOR SL SR ASR, plus MUL when MUL_ITERATIVE = 0):
  - accept at edge N -> DONE at edge N; result_valid high in the following cycle; latency 1.
- Iterative ops (MUL when MUL_ITERATIVE = 1, DIV, MOD):
  - accept at edge N -> RUN with counter 0; one iteration per edge.
  - After edge N+WIDTH: DONE; latency WIDTH.
  - busy is high exactly WIDTH cycles.
- DONE -> IDLE on the next edge unless a new start is accepted; a back-to-back start gives result_valid on consecutive cycles.
- Arithmetic rules (all results modulo 2^WIDTH):
  - ADD/SUB: c = carry-out / borrow (A < B unsigned); v = signed overflow.
  - MUL: low WIDTH bits of the product; c = 1 if the high half is nonzero.
  - SL/SR: if B >= WIDTH, result 0.
  - ASR: sign fill; if B >= WIDTH, result is all copies of A[WIDTH-1].
  - DIV/MOD: unsigned restoring division. If B = 0, DIV gives all-ones, MOD gives A, dz = 1.
  - z = (result == 0) and n = result[WIDTH-1] for every op. c, v and dz are 0 where not defined.
- Undefined alu_operation or alu_operand encoding: completes in 1 cycle with result 0 and flags 0 (no X propagation).
- Reset mid-RUN: aborts immediately; no result_valid is produced.

Decomposition:
- Package cpu_common:
  - extend alu_operation_t with ALU_ASR, ALU_DIV, ALU_MOD (4-bit enum);
  - add alu_flags_t packed struct {z, n, c, v, dz};
  - add FSM enum alu_state_t {ALU_IDLE, ALU_RUN, ALU_DONE}.
- One sub-module, alu_iterative_unit: shift-add multiplier and restoring divider sharing one WIDTH-bit adder/subtractor, counter and accumulator. The top level holds the FSM, operand mux, single-cycle ops and flag logic.

Test Plan:
1. WIDTH=8: ADD r0=0xFF, rX=0x01 -> result_valid 1 cycle after accept, result 0x00, z=1, c=1, v=0, busy never 1.
2. WIDTH=8, MUL_ITERATIVE=1: MUL r0=0x10, imm=0x11 -> busy high 8 cycles; result_valid at edge+8; result 0x10, c=1; start pulsed mid-RUN is ignored.
3. WIDTH=8: DIV 200/7 -> 0x1C; MOD 200/7 -> 0x04; DIV 5/0 -> 0xFF with dz=1; MOD 5/0 -> 0x05 with dz=1.
4. WIDTH=8: ASR 0x80 by 3 -> 0xF0, n=1; ASR 0x80 by 9 -> 0xFF; SL 0x01 by 8 -> 0x00, z=1.
5. WIDTH=16: SUB 0x8000 - 0x0001 -> 0x7FFF, v=1, c=0; back-to-back ADDs -> result_valid on two consecutive cycles.
6. Assert rst_async low at RUN cycle 4 of a DIV -> busy, result_valid, result and flags go 0 immediately; no result_valid after reset release.

Source files
------------

// File: rtl/cpu_common.sv
// Shared CPU types: ALU operation/operand encodings, flag bundle and ALU FSM states.
package cpu_common;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SL  = 4'd5,
        ALU_SR  = 4'd6,
        ALU_MUL = 4'd7,
        ALU_ASR = 4'd8,
        ALU_DIV = 4'd9,
        ALU_MOD = 4'd10
    } alu_operation_t;

    typedef enum logic [1:0] {
        ALU_RX        = 2'd0,
        ALU_IMMEDIATE = 2'd1
    } alu_operand_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
        logic dz;
    } alu_flags_t;

    typedef enum logic [1:0] {
        ALU_IDLE = 2'd0,
        ALU_RUN  = 2'd1,
        ALU_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_iterative_unit.sv
// Shift-add multiplier and restoring divider sharing one adder/subtractor,
// iteration counter and {acc, q} accumulator pair.
module alu_iterative_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_mul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] lo_next,
    output logic [WIDTH-1:0] hi_next
);
    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] b_r;
    logic             mul_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH:0]   x_s;
    logic [WIDTH:0]   sum_s;

    assign last = (cnt_r == LAST_CNT);

    // Shared adder: multiply adds B to the high half, divide trial-subtracts B from the shifted remainder.
    always_comb begin
        x_s     = {WIDTH+1{1'b0}};
        sum_s   = {WIDTH+1{1'b0}};
        lo_next = q_r;
        hi_next = acc_r;
        if (mul_r) begin
            x_s   = {1'b0, acc_r};
            sum_s = x_s + {1'b0, b_r};
            if (q_r[0]) begin
                hi_next = sum_s[WIDTH:1];
                lo_next = {sum_s[0], q_r[MSB:1]};
            end else begin
                hi_next = {1'b0, acc_r[MSB:1]};
                lo_next = {acc_r[0], q_r[MSB:1]};
            end
        end else begin
            x_s   = {acc_r, q_r[MSB]};
            sum_s = x_s - {1'b0, b_r};
            // A borrow out of the top bit means the trial subtraction went negative: restore.
            if (!sum_s[WIDTH]) begin
                hi_next = sum_s[MSB:0];
                lo_next = {q_r[MSB-1:0], 1'b1};
            end else begin
                hi_next = {acc_r[MSB-1:0], q_r[MSB]};
                lo_next = {q_r[MSB-1:0], 1'b0};
            end
        end
    end

    // Operand capture on load, one iteration per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {WIDTH{1'b0}};
            q_r   <= {WIDTH{1'b0}};
            b_r   <= {WIDTH{1'b0}};
            mul_r <= 1'b0;
            cnt_r <= {CW{1'b0}};
        end else if (load) begin
            acc_r <= {WIDTH{1'b0}};
            q_r   <= a;
            b_r   <= b;
            mul_r <= is_mul;
            cnt_r <= {CW{1'b0}};
        end else if (step) begin
            acc_r <= hi_next;
            q_r   <= lo_next;
            cnt_r <= cnt_r + CW'(1);
        end else begin
            acc_r <= acc_r;
            q_r   <= q_r;
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Registered multi-cycle ALU: start/busy/result_valid handshake, single-cycle ops
// computed on accept, MUL/DIV/MOD delegated to alu_iterative_unit.
module alu_multicycle
    import cpu_common::*;
#(
    parameter int WIDTH         = 8,
    parameter bit MUL_ITERATIVE = 1'b1
) (
    input  logic           clk,
    input  logic           rst_async,
    input  logic           start,
    input  alu_operation_t alu_operation,
    input  alu_operand_t   alu_operand,
    input  logic [WIDTH-1:0] r0,
    input  logic [WIDTH-1:0] rX,
    input  logic [WIDTH-1:0] immediate,
    output logic           busy,
    output logic           result_valid,
    output logic [WIDTH-1:0] alu_result,
    output alu_flags_t     alu_flags
);
    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH:0] WIDTH_V = (WIDTH + 1)'(WIDTH);

    alu_state_t       state_r;
    alu_operation_t   op_r;
    logic             div_zero_r;
    logic             busy_r;
    logic             valid_r;
    logic [WIDTH-1:0] result_r;
    alu_flags_t       flags_r;

    logic [WIDTH-1:0]   b_s;
    logic               operand_ok_s;
    logic               accept_s;
    logic               iter_op_s;
    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     sub_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   asr_s;
    logic               shift_big_s;
    logic [WIDTH-1:0]   single_res_s;
    logic               single_c_s;
    logic               single_v_s;
    logic               single_def_s;
    logic [WIDTH-1:0]   single_out_s;
    alu_flags_t         single_flags_s;
    logic               it_last_s;
    logic [WIDTH-1:0]   it_lo_s;
    logic [WIDTH-1:0]   it_hi_s;
    logic [WIDTH-1:0]   it_res_s;
    alu_flags_t         it_flags_s;

    assign busy         = busy_r;
    assign result_valid = valid_r;
    assign alu_result   = result_r;
    assign alu_flags    = flags_r;

    // Operand B select; an unknown encoding marks the request as undefined.
    always_comb begin
        case (alu_operand)
            ALU_RX:        begin b_s = rX;        operand_ok_s = 1'b1; end
            ALU_IMMEDIATE: begin b_s = immediate; operand_ok_s = 1'b1; end
            default:       begin b_s = {WIDTH{1'b0}}; operand_ok_s = 1'b0; end
        endcase
    end

    assign accept_s    = start && ((state_r == ALU_IDLE) || (state_r == ALU_DONE));
    assign iter_op_s   = operand_ok_s && ((alu_operation == ALU_DIV) || (alu_operation == ALU_MOD) ||
                                          ((alu_operation == ALU_MUL) && MUL_ITERATIVE));
    assign add_s       = {1'b0, r0} + {1'b0, b_s};
    assign sub_s       = {1'b0, r0} - {1'b0, b_s};
    assign prod_s      = {{WIDTH{1'b0}}, r0} * {{WIDTH{1'b0}}, b_s};
    assign asr_s       = $unsigned($signed(r0) >>> b_s);
    assign shift_big_s = ({1'b0, b_s} >= WIDTH_V);

    // Single-cycle datapath evaluated from live inputs; registered on accept.
    always_comb begin
        single_res_s = {WIDTH{1'b0}};
        single_c_s   = 1'b0;
        single_v_s   = 1'b0;
        single_def_s = 1'b1;
        case (alu_operation)
            ALU_ADD: begin
                single_res_s = add_s[MSB:0];
                single_c_s   = add_s[WIDTH];
                single_v_s   = (r0[MSB] == b_s[MSB]) && (add_s[MSB] != r0[MSB]);
            end
            ALU_SUB: begin
                single_res_s = sub_s[MSB:0];
                single_c_s   = sub_s[WIDTH];
                single_v_s   = (r0[MSB] != b_s[MSB]) && (sub_s[MSB] != r0[MSB]);
            end
            ALU_AND: single_res_s = r0 & b_s;
            ALU_OR:  single_res_s = r0 | b_s;
            ALU_XOR: single_res_s = r0 ^ b_s;
            ALU_SL:  single_res_s = shift_big_s ? {WIDTH{1'b0}} : (r0 << b_s);
            ALU_SR:  single_res_s = shift_big_s ? {WIDTH{1'b0}} : (r0 >> b_s);
            ALU_ASR: single_res_s = shift_big_s ? {WIDTH{r0[MSB]}} : asr_s;
            ALU_MUL: begin
                single_res_s = prod_s[MSB:0];
                single_c_s   = |prod_s[2*WIDTH-1:WIDTH];
            end
            default: single_def_s = 1'b0;
        endcase
    end

    // Undefined requests collapse to a zero result with all flags clear.
    always_comb begin
        if (single_def_s && operand_ok_s) begin
            single_out_s   = single_res_s;
            single_flags_s = '{z: (single_res_s == {WIDTH{1'b0}}), n: single_res_s[MSB],
                               c: single_c_s, v: single_v_s, dz: 1'b0};
        end else begin
            single_out_s   = {WIDTH{1'b0}};
            single_flags_s = '{default: 1'b0};
        end
    end

    alu_iterative_unit #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .rst_n   (rst_async),
        .load    (accept_s && iter_op_s),
        .step    (state_r == ALU_RUN),
        .is_mul  (alu_operation == ALU_MUL),
        .a       (r0),
        .b       (b_s),
        .last    (it_last_s),
        .lo_next (it_lo_s),
        .hi_next (it_hi_s)
    );

    // Iterative result selection from the unit's final-iteration values.
    always_comb begin
        it_res_s   = it_lo_s;
        it_flags_s = '{default: 1'b0};
        case (op_r)
            ALU_MUL: it_flags_s.c  = |it_hi_s;
            ALU_MOD: begin
                it_res_s      = it_hi_s;
                it_flags_s.dz = div_zero_r;
            end
            default: it_flags_s.dz = div_zero_r;
        endcase
        it_flags_s.z = (it_res_s == {WIDTH{1'b0}});
        it_flags_s.n = it_res_s[MSB];
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            state_r    <= ALU_IDLE;
            op_r       <= ALU_ADD;
            div_zero_r <= 1'b0;
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
            result_r   <= {WIDTH{1'b0}};
            flags_r    <= '{default: 1'b0};
        end else begin
            case (state_r)
                ALU_IDLE, ALU_DONE: begin
                    if (accept_s && iter_op_s) begin
                        state_r    <= ALU_RUN;
                        op_r       <= alu_operation;
                        div_zero_r <= (b_s == {WIDTH{1'b0}});
                        busy_r     <= 1'b1;
                        valid_r    <= 1'b0;
                    end else if (accept_s) begin
                        state_r  <= ALU_DONE;
                        busy_r   <= 1'b0;
                        valid_r  <= 1'b1;
                        result_r <= single_out_s;
                        flags_r  <= single_flags_s;
                    end else begin
                        state_r <= ALU_IDLE;
                        busy_r  <= 1'b0;
                        valid_r <= 1'b0;
                    end
                end
                ALU_RUN: begin
                    if (it_last_s) begin
                        state_r  <= ALU_DONE;
                        busy_r   <= 1'b0;
                        valid_r  <= 1'b1;
                        result_r <= it_res_s;
                        flags_r  <= it_flags_s;
                    end else begin
                        state_r <= ALU_RUN;
                        busy_r  <= 1'b1;
                        valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ALU_IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: an 8-bit iterative-MUL instance and a 16-bit instance.
module tb_alu_multicycle;
    import cpu_common::*;

    logic clk = 1'b0;
    logic rst_async = 1'b0;
    always #5 clk = ~clk;

    logic           start8 = 1'b0;
    alu_operation_t op8 = ALU_ADD;
    alu_operand_t   opnd8 = ALU_RX;
    logic [7:0]     a8 = 8'h00, x8 = 8'h00, imm8 = 8'h00;
    logic           busy8, valid8;
    logic [7:0]     res8;
    alu_flags_t     flags8;

    logic           start16 = 1'b0;
    alu_operation_t op16 = ALU_ADD;
    alu_operand_t   opnd16 = ALU_RX;
    logic [15:0]    a16 = 16'h0000, x16 = 16'h0000, imm16 = 16'h0000;
    logic           busy16, valid16;
    logic [15:0]    res16;
    alu_flags_t     flags16;

    int checks = 0;
    int failures = 0;

    alu_multicycle #(.WIDTH(8), .MUL_ITERATIVE(1'b1)) dut8 (
        .clk(clk), .rst_async(rst_async), .start(start8), .alu_operation(op8),
        .alu_operand(opnd8), .r0(a8), .rX(x8), .immediate(imm8),
        .busy(busy8), .result_valid(valid8), .alu_result(res8), .alu_flags(flags8)
    );

    alu_multicycle #(.WIDTH(16), .MUL_ITERATIVE(1'b1)) dut16 (
        .clk(clk), .rst_async(rst_async), .start(start16), .alu_operation(op16),
        .alu_operand(opnd16), .r0(a16), .rX(x16), .immediate(imm16),
        .busy(busy16), .result_valid(valid16), .alu_result(res16), .alu_flags(flags16)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request on dut8 and wait (bounded) for result_valid; optionally pulse start at RUN cycle 'poke'.
    task automatic run8(input logic [3:0] op, input logic [1:0] opnd, input logic [7:0] a,
                        input logic [7:0] x, input logic [7:0] imm, input int poke,
                        output int lat, output int bcnt);
        op8 = alu_operation_t'(op);
        opnd8 = alu_operand_t'(opnd);
        a8 = a; x8 = x; imm8 = imm;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        bcnt = 0;
        while (valid8 !== 1'b1 && lat < 40) begin
            if (busy8 === 1'b1) bcnt++;
            start8 = (lat == poke);
            if (lat == poke) op8 = ALU_ADD;
            @(posedge clk); #1;
            lat++;
        end
        start8 = 1'b0;
    endtask

    task automatic op8_check(input string tag, input logic [3:0] op, input logic [1:0] opnd,
                             input logic [7:0] a, input logic [7:0] x, input logic [7:0] imm,
                             input int poke, input int exp_lat, input logic [7:0] exp_res,
                             input logic [4:0] exp_fl);
        int lat, bcnt;
        logic [4:0] fl;
        run8(op, opnd, a, x, imm, poke, lat, bcnt);
        fl = flags8;
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, " busy_cycles"}, 32'(bcnt), 32'(exp_lat));
        check_eq({tag, " result"}, 32'(res8), 32'(exp_res));
        check_eq({tag, " flags"}, 32'(fl), 32'(exp_fl));
        check_eq({tag, " busy_at_done"}, 32'(busy8), 32'd0);
    endtask

    initial begin
        logic [4:0] fl;
        int vcount;

        #2;
        fl = flags8;
        check_eq("reset busy", 32'(busy8), 32'd0);
        check_eq("reset valid", 32'(valid8), 32'd0);
        check_eq("reset result", 32'(res8), 32'd0);
        check_eq("reset flags", 32'(fl), 32'd0);
        check_eq("reset result16", 32'(res16), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_async = 1'b1;
        @(posedge clk); #1;

        // flags are {z, n, c, v, dz}
        op8_check("add_wrap", ALU_ADD, ALU_RX, 8'hFF, 8'h01, 8'h00, -1, 0, 8'h00, 5'b10100);
        op8_check("mul_iter", ALU_MUL, ALU_IMMEDIATE, 8'h10, 8'h33, 8'h11, 3, 8, 8'h10, 5'b00100);
        @(posedge clk); #1;
        check_eq("mul ignored_start", 32'(valid8), 32'd0);
        check_eq("mul result_hold", 32'(res8), 32'h10);
        op8_check("div", ALU_DIV, ALU_RX, 8'hC8, 8'h07, 8'h00, -1, 8, 8'h1C, 5'b00000);
        op8_check("mod", ALU_MOD, ALU_RX, 8'hC8, 8'h07, 8'h00, -1, 8, 8'h04, 5'b00000);
        op8_check("div_zero", ALU_DIV, ALU_RX, 8'h05, 8'h00, 8'h00, -1, 8, 8'hFF, 5'b01001);
        op8_check("mod_zero", ALU_MOD, ALU_RX, 8'h05, 8'h00, 8'h00, -1, 8, 8'h05, 5'b00001);

        // Reset during the fourth RUN cycle of a DIV.
        op8 = ALU_DIV; opnd8 = ALU_RX; a8 = 8'hC8; x8 = 8'h07;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check_eq("rst_mid busy_before", 32'(busy8), 32'd1);
        rst_async = 1'b0;
        #1;
        fl = flags8;
        check_eq("rst_mid busy", 32'(busy8), 32'd0);
        check_eq("rst_mid valid", 32'(valid8), 32'd0);
        check_eq("rst_mid result", 32'(res8), 32'd0);
        check_eq("rst_mid flags", 32'(fl), 32'd0);
        @(posedge clk); #1;
        rst_async = 1'b1;
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (valid8 === 1'b1) vcount++;
        end
        check_eq("rst_mid no_valid_after", 32'(vcount), 32'd0);

        op8_check("asr3", ALU_ASR, ALU_RX, 8'h80, 8'h03, 8'h00, -1, 0, 8'hF0, 5'b01000);
        op8_check("asr9", ALU_ASR, ALU_RX, 8'h80, 8'h09, 8'h00, -1, 0, 8'hFF, 5'b01000);
        op8_check("sl8", ALU_SL, ALU_RX, 8'h01, 8'h08, 8'h00, -1, 0, 8'h00, 5'b10000);
        op8_check("sr4", ALU_SR, ALU_IMMEDIATE, 8'hF0, 8'h00, 8'h04, -1, 0, 8'h0F, 5'b00000);
        op8_check("xor_imm", ALU_XOR, ALU_IMMEDIATE, 8'hAA, 8'h00, 8'h55, -1, 0, 8'hFF, 5'b01000);
        op8_check("undef_op", 4'd12, ALU_RX, 8'h55, 8'h01, 8'h00, -1, 0, 8'h00, 5'b00000);
        op8_check("undef_operand", ALU_ADD, 2'd3, 8'h03, 8'h04, 8'h04, -1, 0, 8'h00, 5'b00000);

        // 16-bit: signed overflow on SUB, then back-to-back ADDs.
        op16 = ALU_SUB; opnd16 = ALU_RX; a16 = 16'h8000; x16 = 16'h0001;
        start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        fl = flags16;
        check_eq("sub16 valid", 32'(valid16), 32'd1);
        check_eq("sub16 result", 32'(res16), 32'h7FFF);
        check_eq("sub16 flags", 32'(fl), 32'(5'b00010));
        @(posedge clk); #1;
        op16 = ALU_ADD; a16 = 16'h1234; x16 = 16'h0001;
        start16 = 1'b1;
        @(posedge clk); #1;
        fl = flags16;
        check_eq("b2b first valid", 32'(valid16), 32'd1);
        check_eq("b2b first result", 32'(res16), 32'h1235);
        check_eq("b2b first flags", 32'(fl), 32'd0);
        a16 = 16'hFFFF; x16 = 16'h0002;
        @(posedge clk); #1;
        start16 = 1'b0;
        fl = flags16;
        check_eq("b2b second valid", 32'(valid16), 32'd1);
        check_eq("b2b second result", 32'(res16), 32'h0001);
        check_eq("b2b second flags", 32'(fl), 32'(5'b00100));
        @(posedge clk); #1;
        check_eq("b2b idle valid", 32'(valid16), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
